matrix_scan_driver: RTL and testbench

Consumes the 128-bit two-colour frame built by the game matrix display logic and drives the physical 8×8 red/green LED dot matrix. It scans one row at a time with a blanking gap between rows, and latches a fresh frame only at frame start so the display never tears. Sits between the frame producers (game/boom display, menu screens) and the board's row/column pins.

---
 rtl/matrix_pkg.sv | 27 ++
 rtl/scan_row_timer.sv | 40 ++++
 rtl/matrix_scan_driver.sv | 80 ++++++++
 tb/tb_matrix_scan_driver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared geometry and colour encoding for the two-colour 8x8 matrix frame.
// Producers and the scan driver both address pixels through pixel_index.
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int PIX_BITS    = 2;
  localparam int ROW_BITS    = 16;

  localparam logic [1:0] COLOR_OFF   = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  localparam logic [1:0] COLOR_BOTH  = 2'b11;

  // Position of each colour inside a pixel pair.
  localparam logic COLOR_RED_BIT   = 1'b0;
  localparam logic COLOR_GREEN_BIT = 1'b1;

  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_DRIVE = 1'b1;

  function automatic logic [6:0] pixel_index(input logic [2:0] r, input logic [2:0] c,
                                             input logic color);
    return 7'(ROW_BITS * int'(r) + PIX_BITS * int'(c) + int'(color));
  endfunction

endpackage

// File: rtl/scan_row_timer.sv
// Row slot timer: counts cycles within a row slot, steps the row index and
// flags the frame-start cycle. Held at row 0 / cnt 0 whenever en is low.
module scan_row_timer
  import matrix_pkg::*;
#(
  parameter int ROW_DIV = 1000,
  parameter int BLANK   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] row,
  output logic [0:0] phase,
  output logic       frame_start
);

  localparam int CNT_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;

  if (BLANK < 1 || BLANK >= ROW_DIV) begin : g_bad_blank
    $error("scan_row_timer: BLANK must satisfy 1 <= BLANK < ROW_DIV");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      row <= '0;
    end else if (cnt == CNT_W'(ROW_DIV - 1)) begin
      cnt <= '0;
      row <= row + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign phase       = (cnt < CNT_W'(BLANK)) ? PH_BLANK : PH_DRIVE;
  assign frame_start = en && (cnt == '0) && (row == 3'd0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Scans a latched 128-bit red/green frame onto an 8x8 LED matrix, one row per
// slot with a blanking gap; the frame is captured only at frame start.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROW_DIV        = 1000,
  parameter int BLANK          = 8,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] matrixData,
  output logic [7:0]   rowSel,
  output logic [7:0]   colR,
  output logic [7:0]   colG,
  output logic         frameSync
);

  localparam logic [7:0] ROW_OFF = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [2:0]   row;
  logic [0:0]   phase;
  logic         frame_start;
  logic [127:0] fb;
  logic [7:0]   row_d;
  logic [7:0]   col_r_d;
  logic [7:0]   col_g_d;

  scan_row_timer #(
    .ROW_DIV (ROW_DIV),
    .BLANK   (BLANK)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .row         (row),
    .phase       (phase),
    .frame_start (frame_start)
  );

  // The only write point for fb, so a frame never changes mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb <= '0;
    end else if (frame_start) begin
      fb <= matrixData;
    end
  end

  always_comb begin
    row_d   = ROW_OFF;
    col_r_d = COL_OFF;
    col_g_d = COL_OFF;
    if (en && phase == PH_DRIVE) begin
      row_d = ROW_OFF ^ (8'b1 << row);
      for (int c = 0; c < MATRIX_COLS; c++) begin
        col_r_d[c] = fb[pixel_index(row, 3'(c), COLOR_RED_BIT)] ^ COL_ACTIVE_LOW;
        col_g_d[c] = fb[pixel_index(row, 3'(c), COLOR_GREEN_BIT)] ^ COL_ACTIVE_LOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rowSel    <= ROW_OFF;
      colR      <= COL_OFF;
      colG      <= COL_OFF;
      frameSync <= 1'b0;
    end else begin
      rowSel    <= row_d;
      colR      <= col_r_d;
      colG      <= col_g_d;
      frameSync <= frame_start;
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Randomized bench for matrix_scan_driver: a time-based reference model
// predicts every output cycle; directed phases hit the documented corner cases.
module tb_matrix_scan_driver;

  localparam int RD = 10;
  localparam int BL = 2;
  localparam int FP = 8 * RD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [127:0] matrixData = '0;
  logic [7:0]   rowSel;
  logic [7:0]   colR;
  logic [7:0]   colG;
  logic         frameSync;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles elapsed since scan start, and the displayed frame.
  int           t_m  = 0;
  logic [127:0] fb_m = '0;
  logic [24:0]  exp_q[$];

  matrix_scan_driver #(
    .ROW_DIV        (RD),
    .BLANK          (BL),
    .ROW_ACTIVE_LOW (1'b1),
    .COL_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .matrixData (matrixData),
    .rowSel     (rowSel),
    .colR       (colR),
    .colG       (colG),
    .frameSync  (frameSync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Predicts {rowSel, colR, colG, frameSync} seen after the coming clock edge.
  function automatic logic [24:0] model_step();
    logic [7:0] r_sel, c_r, c_g;
    logic       sync;
    int         row, cnt;
    r_sel = 8'hFF;
    c_r   = 8'h00;
    c_g   = 8'h00;
    sync  = 1'b0;
    if (rst) begin
      fb_m = '0;
      t_m  = 0;
    end else if (!en) begin
      t_m = 0;
    end else begin
      cnt = t_m % RD;
      row = (t_m / RD) % 8;
      if (t_m % FP == 0) begin
        sync = 1'b1;
        fb_m = matrixData;
      end
      if (cnt >= BL) begin
        r_sel = ~(8'b1 << row);
        for (int c = 0; c < 8; c++) begin
          c_r[c] = fb_m[16 * row + 2 * c];
          c_g[c] = fb_m[16 * row + 2 * c + 1];
        end
      end
      t_m++;
    end
    return {r_sel, c_r, c_g, sync};
  endfunction

  task automatic cycle();
    logic [24:0] e;
    exp_q.push_back(model_step());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rowSel", 32'(rowSel), 32'(e[24:17]));
    check("colR", 32'(colR), 32'(e[16:9]));
    check("colG", 32'(colG), 32'(e[8:1]));
    check("frameSync", 32'(frameSync), 32'(e[0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model reaches the given row/cnt position (bounded).
  task automatic run_to(input int row, input int cnt);
    int budget;
    budget = 2 * FP;
    while ((t_m % FP) != row * RD + cnt && budget > 0) begin
      cycle();
      budget--;
    end
    check("run_to_timeout", 32'(budget == 0), 32'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pat;
    // Reset held for three cycles.
    rst = 1'b1;
    en  = 1'b0;
    run(3);
    rst = 1'b0;
    run(2);

    // Single red pixel at (0,0).
    matrixData = 128'h1;
    en = 1'b1;
    run(FP + 5);

    // Green (7,7) plus both colours at (3,2), picked up at the next frame start.
    pat = '0;
    pat[127] = 1'b1;
    pat[52]  = 1'b1;
    pat[53]  = 1'b1;
    matrixData = pat;
    run(2 * FP);

    // Tear-free latch: new data at cycle 35 of a frame stays hidden until the next one.
    run_to(3, 5);
    matrixData = rand128();
    run(FP);
    run_to(0, 1);
    matrixData = rand128();
    run(FP);

    // Enable gating mid-row.
    run_to(2, 5);
    en = 1'b0;
    run(4);
    en = 1'b1;
    matrixData = rand128();
    run(FP / 2);

    // Reset in the middle of row 5 drive.
    run_to(5, 6);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    matrixData = rand128();
    run(FP + 3);

    // Randomized traffic: data churn, enable drops and occasional resets.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) matrixData = rand128();
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 19) == 0);
      run($urandom_range(1, 40));
    end
    rst = 1'b0;
    en  = 1'b1;
    run(FP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
